// File: rtl/viterbi_codec.sv
// Rate-1/2 K=4 convolutional encoder, error-injecting channel register and hard-decision Viterbi decoder.
// Latency: encoder 1 clk; channel 1 clk; decoder emits bit k-DEPTH on the edge that accepts symbol k.
// No backpressure: a valid input is accepted every cycle; idle cycles simply freeze the pipeline state.

// Encoder: generators 17/15 octal, state {s2,s1,s0} with s2 the newest bit.
// Latency: 1 clk from enable_i/d_in to valid_o/d_out.
// No backpressure: d_out and state hold while enable_i is low.
module encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       valid_o,
    output logic [1:0] d_out
);

    logic [2:0] state;

    // Shift the new bit into the state and register the code symbol {g1,g0}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= 3'd0;
            d_out   <= 2'd0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= enable_i;
            if (enable_i) begin
                d_out[1] <= d_in ^ state[2] ^ state[1] ^ state[0];
                d_out[0] <= d_in ^ state[2] ^ state[0];
                state    <= {d_in, state[2:1]};
            end
        end
    end

endmodule

// Decoder: 8-state hard-decision Viterbi with register-exchange survivors.
// Latency: the edge accepting symbol k drives bit k-DEPTH (0 for k < DEPTH).
// No backpressure: metrics, survivors and d_out hold while enable is low.
module decoder #(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] d_in,
    output logic       d_out
);

    logic [7:0]       pm       [8];
    logic [DEPTH-1:0] surv     [8];
    logic [7:0]       cand0    [8];
    logic [7:0]       cand1    [8];
    logic [7:0]       acs_pm   [8];
    logic [DEPTH-1:0] nxt_surv [8];
    logic [7:0]       min_new;
    logic [2:0]       best;
    logic [7:0]       best_pm;

    // Predecessor of state {u,s2,s1} is {s2,s1,s0}.
    function automatic logic [2:0] pred_idx(input int s, input logic s0);
        logic [2:0] st;
        st = 3'(s);
        return {st[1:0], s0};
    endfunction

    // Bit that enters the encoder on a transition into state s.
    function automatic logic new_bit(input int s);
        logic [2:0] st;
        st = 3'(s);
        return st[2];
    endfunction

    // Encoder output for the transition from {st[1:0],s0} into st.
    function automatic logic [1:0] branch_sym(input int s, input logic s0);
        logic [2:0] st;
        st = 3'(s);
        return {st[2] ^ st[1] ^ st[0] ^ s0, st[2] ^ st[1] ^ s0};
    endfunction

    function automatic logic [7:0] hdist(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {7'd0, x[0]} + {7'd0, x[1]};
    endfunction

    // Add-compare-select for every state; ties resolve to the s0=0 predecessor.
    always_comb begin
        min_new = 8'hFF;
        for (int s = 0; s < 8; s++) begin
            cand0[s] = pm[pred_idx(s, 1'b0)] + hdist(d_in, branch_sym(s, 1'b0));
            cand1[s] = pm[pred_idx(s, 1'b1)] + hdist(d_in, branch_sym(s, 1'b1));
            if (cand1[s] < cand0[s]) begin
                acs_pm[s]   = cand1[s];
                nxt_surv[s] = {surv[pred_idx(s, 1'b1)][DEPTH-2:0], new_bit(s)};
            end else begin
                acs_pm[s]   = cand0[s];
                nxt_surv[s] = {surv[pred_idx(s, 1'b0)][DEPTH-2:0], new_bit(s)};
            end
            if (acs_pm[s] < min_new) begin
                min_new = acs_pm[s];
            end
        end
    end

    // Best state before the update, lowest index wins a tie.
    always_comb begin
        best    = 3'd0;
        best_pm = pm[0];
        for (int s = 1; s < 8; s++) begin
            if (pm[s] < best_pm) begin
                best    = 3'(s);
                best_pm = pm[s];
            end
        end
    end

    // Commit normalised metrics and survivors, emit the oldest bit of the best path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 8; s++) begin
                pm[s]   <= (s == 0) ? 8'd0 : 8'd16;
                surv[s] <= '0;
            end
            d_out <= 1'b0;
        end else if (enable) begin
            for (int s = 0; s < 8; s++) begin
                pm[s]   <= acs_pm[s] - min_new;
                surv[s] <= nxt_surv[s];
            end
            d_out <= surv[best][DEPTH-1];
        end
    end

endmodule

// Link coding layer: encoder -> channel register (XOR error mask) -> decoder.
// Latency: decoded bit j appears DEPTH accepted symbols plus 2 clks after in_dat bit j.
// No backpressure: err_dat is applied to the symbol built from the in_dat presented with it.
module viterbi_codec #(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    input  logic       in_dat,
    input  logic [1:0] err_dat,
    output logic       sym_vld,
    output logic [1:0] sym_dat,
    output logic       out_vld,
    output logic       out_dat
);

    logic [1:0] err_q;
    logic [1:0] ch_dat;
    logic       ch_vld;

    encoder u_enc (
        .clk      (clk),
        .rst      (rst),
        .enable_i (in_vld),
        .d_in     (in_dat),
        .valid_o  (sym_vld),
        .d_out    (sym_dat)
    );

    // Align the error mask with the encoder output, then corrupt it in the channel register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q   <= 2'd0;
            ch_dat  <= 2'd0;
            ch_vld  <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            err_q   <= err_dat;
            ch_dat  <= sym_dat ^ err_q;
            ch_vld  <= sym_vld;
            out_vld <= ch_vld;
        end
    end

    decoder #(.DEPTH(DEPTH)) u_dec (
        .clk    (clk),
        .rst    (rst),
        .enable (ch_vld),
        .d_in   (ch_dat),
        .d_out  (out_dat)
    );

endmodule

// File: tb/tb_viterbi_codec.sv
// Self-checking bench for viterbi_codec: scoreboard of delayed input bits plus per-scenario checks.
// Expected decoded stream = DEPTH zeros followed by every bit driven with in_vld high.
// Encoder symbols checked against an independent shift-register model.
module tb_viterbi_codec;

    localparam int DEPTH = 32;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic       in_dat;
    logic [1:0] err_dat;
    logic       sym_vld;
    logic [1:0] sym_dat;
    logic       out_vld;
    logic       out_dat;

    int         vectors;
    int         miscompares;
    logic       q [$];
    logic [2:0] es;
    logic [1:0] exp_sym;

    viterbi_codec #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .err_dat (err_dat),
        .sym_vld (sym_vld),
        .sym_dat (sym_dat),
        .out_vld (out_vld),
        .out_dat (out_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every decoder output is compared with the oldest queued bit.
    always @(negedge clk) begin
        if (rst && out_vld) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard: decoder output %0b with empty expectation queue", out_dat);
            end else begin
                logic e;
                e = q.pop_front();
                if (out_dat !== e) begin
                    miscompares++;
                    $display("FAIL decoded_bit: got %0b expected %0b at %0t", out_dat, e, $time);
                end
            end
        end
    end

    task automatic seed_queue();
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(1'b0);
        es = 3'd0;
    endtask

    task automatic drive(input logic en, input logic b, input logic [1:0] e);
        in_vld  = en;
        in_dat  = b;
        err_dat = e;
        if (en) begin
            q.push_back(b);
            exp_sym = {b ^ es[2] ^ es[1] ^ es[0], b ^ es[2] ^ es[0]};
            es      = {b, es[2:1]};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_vld  = 1'b0;
        in_dat  = 1'b0;
        err_dat = 2'b00;
        rst     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        seed_queue();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        in_vld  = 1'b0;
        in_dat  = 1'b0;
        err_dat = 2'b00;
        rst     = 1'b0;
        #2;
        vectors += 4;
        if (sym_vld !== 1'b0) begin miscompares++; $display("FAIL reset_sym_vld: got %0b expected 0", sym_vld); end
        if (sym_dat !== 2'b00) begin miscompares++; $display("FAIL reset_sym_dat: got %b expected 00", sym_dat); end
        if (out_vld !== 1'b0) begin miscompares++; $display("FAIL reset_out_vld: got %0b expected 0", out_vld); end
        if (out_dat !== 1'b0) begin miscompares++; $display("FAIL reset_out_dat: got %0b expected 0", out_dat); end
        apply_reset();
    endtask

    task automatic test_zeros();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0, 2'b00);
            vectors += 2;
            if (sym_dat !== 2'b00) begin miscompares++; $display("FAIL zeros_sym: cycle %0d got %b expected 00", i, sym_dat); end
            if (out_dat !== 1'b0) begin miscompares++; $display("FAIL zeros_out: cycle %0d got %0b expected 0", i, out_dat); end
        end
    endtask

    task automatic test_impulse();
        logic [1:0] tbl [6];
        tbl[0] = 2'b11; tbl[1] = 2'b11; tbl[2] = 2'b10;
        tbl[3] = 2'b11; tbl[4] = 2'b00; tbl[5] = 2'b00;
        apply_reset();
        drive(1'b0, 1'b0, 2'b00);
        vectors++;
        if (sym_vld !== 1'b0) begin miscompares++; $display("FAIL impulse_idle_vld: got %0b expected 0", sym_vld); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i == 0) ? 1'b1 : 1'b0, 2'b00);
            vectors += 2;
            if (sym_vld !== 1'b1) begin miscompares++; $display("FAIL impulse_vld: step %0d got %0b expected 1", i, sym_vld); end
            if (sym_dat !== tbl[i]) begin miscompares++; $display("FAIL impulse_sym: step %0d got %b expected %b", i, sym_dat, tbl[i]); end
        end
        for (int i = 0; i < DEPTH + 4; i++) drive(1'b1, 1'b0, 2'b00);
    endtask

    task automatic test_random(input bit with_errors);
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            logic       b;
            logic [1:0] e;
            b = 1'($urandom_range(0, 1));
            e = (with_errors && (i % 16 == 8)) ? 2'b11 : 2'b00;
            drive(1'b1, b, e);
            vectors++;
            if (sym_dat !== exp_sym) begin
                miscompares++;
                $display("FAIL random_sym: bit %0d got %b expected %b", i, sym_dat, exp_sym);
            end
        end
        for (int i = 0; i < DEPTH + 4; i++) drive(1'b1, 1'b0, 2'b00);
    endtask

    task automatic test_enable_gap();
        logic last_out;
        logic last_sym_vld_seen;
        logic [1:0] held_sym;
        apply_reset();
        last_out = 1'b0;
        last_sym_vld_seen = 1'b0;
        for (int i = 0; i < 40; i++) drive(1'b1, 1'($urandom_range(0, 1)), 2'b00);
        held_sym = sym_dat;
        last_out = out_dat;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                drive(1'b0, 1'($urandom_range(0, 1)), 2'b00);
                vectors++;
                if (sym_dat !== held_sym) begin miscompares++; $display("FAIL gap_sym_hold: cycle %0d got %b expected %b", i, sym_dat, held_sym); end
            end else begin
                drive(1'b1, 1'($urandom_range(0, 1)), 2'b00);
            end
            if (!out_vld) begin
                last_sym_vld_seen = 1'b1;
                vectors++;
                if (out_dat !== last_out) begin miscompares++; $display("FAIL gap_out_hold: cycle %0d got %0b expected %0b", i, out_dat, last_out); end
            end else begin
                last_out = out_dat;
            end
        end
        vectors++;
        if (last_sym_vld_seen !== 1'b1) begin miscompares++; $display("FAIL gap_seen: got %0b expected 1", last_sym_vld_seen); end
        for (int i = 0; i < 40; i++) drive(1'b1, 1'($urandom_range(0, 1)), 2'b00);
        for (int i = 0; i < DEPTH + 4; i++) drive(1'b1, 1'b0, 2'b00);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 50; i++) drive(1'b1, 1'($urandom_range(0, 1)), 2'b00);
        in_vld = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        vectors += 4;
        if (sym_vld !== 1'b0) begin miscompares++; $display("FAIL midrst_sym_vld: got %0b expected 0", sym_vld); end
        if (sym_dat !== 2'b00) begin miscompares++; $display("FAIL midrst_sym_dat: got %b expected 00", sym_dat); end
        if (out_vld !== 1'b0) begin miscompares++; $display("FAIL midrst_out_vld: got %0b expected 0", out_vld); end
        if (out_dat !== 1'b0) begin miscompares++; $display("FAIL midrst_out_dat: got %0b expected 0", out_dat); end
        @(negedge clk);
        seed_queue();
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 2'b00);
            vectors++;
            if (sym_dat !== exp_sym) begin miscompares++; $display("FAIL midrst_sym: bit %0d got %b expected %b", i, sym_dat, exp_sym); end
        end
        for (int i = 0; i < DEPTH + 4; i++) drive(1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        es          = 3'd0;
        exp_sym     = 2'b00;
        rst         = 1'b1;
        in_vld      = 1'b0;
        in_dat      = 1'b0;
        err_dat     = 2'b00;
        #3;
        test_reset();
        test_zeros();
        test_impulse();
        test_random(1'b0);
        test_random(1'b1);
        test_enable_gap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/viterbi_codec.md
# viterbi_codec

Rate-1/2, constraint-length-4 convolutional encoder (`encoder`) and matching hard-decision Viterbi decoder (`decoder`). Together they form the coding layer of the tx/rx link. The encoder output is registered once, passed through a bit-error-injecting channel register, and fed to the decoder. The decoder recovers the original bit stream and corrects isolated channel bit errors.

## Interface
Parameters:
- `DEPTH`, default 32: decoder survivor (register-exchange) length, in decoded bits. Legal range 16..64.

Clock/reset (already decided): one clock; reset is asynchronous and active-low. Ports are named `clk` and `rst`, shared by both modules.

`encoder` ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  async active-low reset
- `enable_i`  in  1  input bit valid
- `d_in`  in  1  information bit
- `valid_o`  out  1  `d_out` valid
- `d_out`  out  2  code symbol {g1,g0}

`decoder` ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  async active-low reset
- `enable`  in  1  `d_in` symbol valid
- `d_in`  in  2  received symbol {g1,g0}, possibly corrupted
- `d_out`  out  1  decoded bit

## Operation
Encoder:
- 3-bit state {s2,s1,s0}; s2 is the most recent input.
- On each clock edge with `enable_i`=1, using u=`d_in`:
  - `d_out[1]` <= u^s2^s1^s0 (generator 17 octal)
  - `d_out[0]` <= u^s2^s0 (generator 15 octal)
  - state <= {u,s2,s1}
- With `enable_i`=0: state and `d_out` hold.
- `valid_o` <= `enable_i` every cycle.

Decoder:
- 8 states, using the same state definition as the encoder. State {u,s2,s1} has two predecessors, {s2,s1,0} and {s2,s1,1}. Expected branch symbol is computed from the encoder equations.
- Branch metric = Hamming distance between `d_in` and the expected branch symbol (0..2).
- Add-compare-select per state:
  - new metric = min over the two predecessors of (predecessor metric + branch metric).
  - On a tie, choose the predecessor with s0=0.
- Path metrics are 8-bit unsigned.
  - After each ACS, subtract the minimum new metric from all eight metrics, so the best state is always 0 and no wrap occurs.
  - Reset values: state 0 = 0, all other states = 16.
- Survivors use register exchange: each state keeps a `DEPTH`-bit register.
  - Update: new_surv[s] = {old_surv[pred(s)][DEPTH-2:0], u(s)}.
  - Survivors reset to 0.
- Output on each enabled edge: `d_out` <= old_surv[b][DEPTH-1], where b is the state with the minimum metric before the update (lowest index on ties).
- With `enable`=0: metrics, survivors and `d_out` hold.

## Timing
- All outputs reset to 0: `valid_o`, `d_out` (both modules).
- Encoder latency: 1 clock from `enable_i`/`d_in` to `valid_o`/`d_out`.
- Decoder latency: the edge accepting symbol k (k counted from 0 after reset) drives `d_out` = decoded bit k−DEPTH. For k<DEPTH the output is 0.
- Decoder timing counts only enabled symbols; cycles with `enable`=0 are transparent (no state advance).
- Reset asserted mid-stream: both modules return to their reset state immediately (asynchronous). The first symbol after release is treated as k=0.
- Simultaneous `enable` and a metric tie: the deterministic tie rules above apply; no randomness.

## Test plan
- Reset, `d_in`=0 with enable held for 100 cycles → encoder `d_out`=00 throughout; decoder `d_out`=0 throughout.
- Encoder impulse (one 1, then 0s from reset) → `d_out` sequence 11,11,10,11,00,00…, with `valid_o` high one cycle after `enable_i`.
- 256 random bits through encoder → 1-cycle register → decoder, no errors → decoder output equals the input delayed by DEPTH symbols (+2 cycles of pipeline), zero mismatches.
- Same stream with both bits of one symbol inverted every 16 symbols → zero decoded mismatches.
- `enable` deasserted for 5 cycles mid-stream → decoder `d_out` holds; decoded sequence is unchanged versus the uninterrupted run.
- `rst` pulsed low mid-stream → all outputs 0 immediately; the post-reset stream decodes correctly from k=0.
